demux1way4_stream: RTL and testbench

//  1-to-4 demultiplexer for a valid/ready stream; counterpart of the 4-way-1 mux.

---
 rtl/demux1way4_stream.sv | 80 ++++++++
 tb/tb_demux1way4_stream.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/demux1way4_stream.sv
// demux1way4_stream: 1-to-4 valid/ready stream demux with a one-entry holding
// register and a delivered-word counter on every output channel.

module demux1way4_stream_lane #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             acc,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic             full,
  output logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] count
);
  logic drain;
  assign drain = full & ready;

  // An accept in the same cycle as a drain keeps the slot full (pass-through).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full  <= 1'b0;
      data  <= '0;
      count <= '0;
    end else begin
      if (acc) begin
        full <= 1'b1;
        data <= din;
      end else if (drain) begin
        full <= 1'b0;
      end
      if (drain) count <= count + 1'b1;
    end
  end
endmodule

module demux1way4_stream #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [1:0]           sel,
  output logic [3:0]           out_valid,
  input  logic [3:0]           out_ready,
  output logic [4*WIDTH-1:0]   out_data,
  output logic [4*CNT_W-1:0]   out_count
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0]            full;
  logic [NUM_LANES-1:0]            acc;
  logic [NUM_LANES-1:0][WIDTH-1:0] data;
  logic [NUM_LANES-1:0][CNT_W-1:0] cnt;

  // Ready looks only at the addressed channel, so a stalled lane never blocks others.
  assign in_ready  = !full[sel] | out_ready[sel];
  assign out_valid = full;
  assign out_data  = data;
  assign out_count = cnt;

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    assign acc[gi] = in_valid & in_ready & (sel == 2'(gi));

    demux1way4_stream_lane #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .acc   (acc[gi]),
      .din   (in_data),
      .ready (out_ready[gi]),
      .full  (full[gi]),
      .data  (data[gi]),
      .count (cnt[gi])
    );
  end
endmodule

// File: tb/tb_demux1way4_stream.sv
// Bench for demux1way4_stream: queue-based channel model checked every cycle,
// directed scenarios with literal expectations, then constrained-random traffic.
module tb_demux1way4_stream;
  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data = '0;
  logic [1:0]           sel = '0;
  logic [3:0]           out_valid;
  logic [3:0]           out_ready = '0;
  logic [4*WIDTH-1:0]   out_data;
  logic [4*CNT_W-1:0]   out_count;

  demux1way4_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Model: each channel is a FIFO of at most one word plus a wrapping delivery count.
  logic [WIDTH-1:0] q[4][$];
  logic [WIDTH-1:0] last_d[4];
  int               cnt[4];

  initial for (int i = 0; i < 4; i++) begin last_d[i] = '0; cnt[i] = 0; end

  always @(posedge clk or posedge rst) begin
    bit acc;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin q[i].delete(); last_d[i] = '0; cnt[i] = 0; end
    end else begin
      acc = in_valid && (q[sel].size() == 0 || out_ready[sel]);
      for (int i = 0; i < 4; i++)
        if (q[i].size() > 0 && out_ready[i]) begin
          void'(q[i].pop_front());
          cnt[i] = (cnt[i] + 1) % (1 << CNT_W);
        end
      if (acc) begin q[sel].push_back(in_data); last_d[sel] = in_data; end
    end
  end

  task automatic cmp(input string name, input int ch, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s ch%0d @%0t: got %h expected %h", name, ch, $time, got, exp);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    cmp("in_ready", int'(sel), 32'(in_ready), 32'((q[sel].size() == 0) || out_ready[sel]));
    for (int i = 0; i < 4; i++) begin
      cmp("out_valid", i, 32'(out_valid[i]), 32'(q[i].size() > 0));
      cmp("out_data", i, out_data[i*WIDTH +: WIDTH], last_d[i]);
      if (q[i].size() > 0) cmp("head_word", i, out_data[i*WIDTH +: WIDTH], q[i][0]);
      cmp("out_count", i, 32'(out_count[i*CNT_W +: CNT_W]), 32'(cnt[i]));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic [1:0] s, input logic [3:0] r);
    in_valid = v; in_data = d; sel = s; out_ready = r; #1;
  endtask

  task automatic do_reset();
    drive(1'b0, '0, 2'd0, 4'b0000);
    rst = 1'b1; tick(); rst = 1'b0; #1;
  endtask

  function automatic logic [31:0] dslice(input int i);
    return out_data[i*WIDTH +: WIDTH];
  endfunction

  function automatic logic [31:0] cslice(input int i);
    return 32'(out_count[i*CNT_W +: CNT_W]);
  endfunction

  logic [WIDTH-1:0] hold_d;
  logic [1:0]       hold_s;

  initial begin
    #1 rst = 1'b1;
    #1 chk_en = 1'b1;
    tick(); rst = 1'b0; #1;
    cmp("rst_valid", 0, 32'(out_valid), 32'h0);

    // Single route, blocked second word, independent channel
    drive(1'b1, 32'h000000A5, 2'd2, 4'b0000);
    tick();
    cmp("route_valid", 2, 32'(out_valid), 32'h4);
    cmp("route_data", 2, dslice(2), 32'hA5);
    drive(1'b1, 32'h000000BB, 2'd2, 4'b0000);
    cmp("blocked_rdy", 2, 32'(in_ready), 32'h0);
    drive(1'b1, 32'h00000011, 2'd0, 4'b0000);
    cmp("other_rdy", 0, 32'(in_ready), 32'h1);
    tick();
    cmp("two_valid", 0, 32'(out_valid), 32'h5);

    // Streaming through ch1
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, WIDTH'(k), 2'd1, 4'b0010);
      cmp("stream_rdy", 1, 32'(in_ready), 32'h1);
      tick();
      cmp("stream_data", 1, dslice(1), 32'(k));
    end
    drive(1'b0, '0, 2'd1, 4'b0010);
    tick();
    cmp("stream_cnt", 1, cslice(1), 32'd4);
    cmp("stream_empty", 1, 32'(out_valid), 32'h0);

    // Fill / stall / release
    do_reset();
    for (int s = 0; s < 4; s++) begin
      drive(1'b1, WIDTH'(32'h100 + s), 2'(s), 4'b0000);
      tick();
    end
    cmp("fill_valid", 0, 32'(out_valid), 32'hF);
    for (int s = 0; s < 4; s++) begin
      drive(1'b0, '0, 2'(s), 4'b0000);
      cmp("full_rdy", s, 32'(in_ready), 32'h0);
    end
    drive(1'b0, '0, 2'd0, 4'b1111);
    tick();
    drive(1'b0, '0, 2'd0, 4'b0000);
    cmp("release_valid", 0, 32'(out_valid), 32'h0);
    for (int i = 0; i < 4; i++) cmp("release_cnt", i, cslice(i), 32'd1);

    // Async reset mid-cycle with all channels full
    for (int s = 0; s < 4; s++) begin
      drive(1'b1, WIDTH'(32'h200 + s), 2'(s), 4'b0000);
      tick();
    end
    drive(1'b1, 32'hDEAD, 2'd1, 4'b0000);
    #2 rst = 1'b1; #1;
    cmp("arst_valid", 0, 32'(out_valid), 32'h0);
    for (int i = 0; i < 4; i++) begin
      cmp("arst_data", i, dslice(i), 32'h0);
      cmp("arst_cnt", i, cslice(i), 32'h0);
    end
    tick();
    cmp("arst_hold", 0, 32'(out_valid), 32'h0);
    rst = 1'b0;
    drive(1'b0, '0, 2'd0, 4'b0000);

    // Counter wrap on ch3
    do_reset();
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, WIDTH'(100 + k), 2'd3, 4'b1000);
      tick();
    end
    drive(1'b0, '0, 2'd3, 4'b1000);
    tick();
    cmp("wrap_cnt", 3, cslice(3), 32'd0);
    drive(1'b1, WIDTH'(500), 2'd3, 4'b1000);
    tick();
    drive(1'b0, '0, 2'd3, 4'b1000);
    tick();
    cmp("wrap_cnt17", 3, cslice(3), 32'd1);

    // Simultaneous accept and drain on ch2
    do_reset();
    drive(1'b1, WIDTH'(7), 2'd2, 4'b0000);
    tick();
    drive(1'b1, WIDTH'(9), 2'd2, 4'b0100);
    cmp("simul_rdy", 2, 32'(in_ready), 32'h1);
    tick();
    drive(1'b0, '0, 2'd2, 4'b0000);
    cmp("simul_valid", 2, 32'(out_valid[2]), 32'h1);
    cmp("simul_data", 2, dslice(2), 32'd9);
    cmp("simul_cnt", 2, cslice(2), 32'd1);

    // Constrained-random traffic honouring the source-hold rule
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (in_valid && !in_ready) begin
        hold_d = in_data; hold_s = sel;
        drive(1'b1, hold_d, hold_s, 4'($urandom));
      end else begin
        drive(1'($urandom_range(0, 3) != 0), WIDTH'($urandom), 2'($urandom), 4'($urandom));
      end
      if (c % 700 == 699) begin
        #2 rst = 1'b1; #2 rst = 1'b0;
      end
      tick();
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
